// File: rtl/dvfs_pkg.sv
// Shared DVFS definitions: sequencer states, operating-point codes
// agreed with the policy FSM, and the default post-reset level.
package dvfs_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_V_UP      = 3'd1,
      ST_F_ADJ     = 3'd2,
      ST_V_DN      = 3'd3,
      ST_WAIT_DONE = 3'd4
   } dvfs_state_e;

   localparam logic [1:0] V_THERMAL = 2'b00;
   localparam logic [1:0] V_BATTERY = 2'b00;
   localparam logic [1:0] V_NORMAL  = 2'b01;
   localparam logic [1:0] V_PERF    = 2'b11;

   localparam logic [2:0] F_THERMAL = 3'b000;
   localparam logic [2:0] F_BATTERY = 3'b001;
   localparam logic [2:0] F_NORMAL  = 3'b010;
   localparam logic [2:0] F_PERF    = 3'b111;

   localparam logic [1:0] DEF_V_RST = V_NORMAL;
   localparam logic [2:0] DEF_F_RST = F_NORMAL;

endpackage

// File: rtl/dvfs_settle_timer.sv
// Settle down-counter; expired while the count sits at zero.
module dvfs_settle_timer #(
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   output logic          expired
);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == '0);

endmodule

// File: rtl/dvfs_step_sequencer.sv
// Walks one domain's rail and clock to a target level one code at a time,
// raising voltage before frequency and lowering frequency before voltage.
module dvfs_step_sequencer
   import dvfs_pkg::*;
#(
   parameter int            VW       = 2,
   parameter int            FW       = 3,
   parameter int            CW       = 8,
   parameter int            V_SETTLE = 4,
   parameter int            F_SETTLE = 2,
   parameter logic [VW-1:0] V_RST    = DEF_V_RST,
   parameter logic [FW-1:0] F_RST    = DEF_F_RST
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [VW-1:0] tgt_v,
   input  logic [FW-1:0] tgt_f,
   input  logic          tgt_valid,
   output logic          tgt_ready,
   output logic [VW-1:0] cur_v,
   output logic [FW-1:0] cur_f,
   output logic          busy,
   output logic          done
);

   localparam logic [CW-1:0] V_LD = CW'(V_SETTLE - 1);
   localparam logic [CW-1:0] F_LD = CW'(F_SETTLE - 1);

   dvfs_state_e   state_q, state_d;
   logic [VW-1:0] cur_v_q, cur_v_d;
   logic [FW-1:0] cur_f_q, cur_f_d;
   logic [VW-1:0] tv_q, tv_d;
   logic [FW-1:0] tf_q, tf_d;
   logic          done_q, done_d;
   logic          ld;
   logic [CW-1:0] ld_val;
   logic          expired;
   logic [VW-1:0] v_nxt;
   logic [FW-1:0] f_nxt;

   dvfs_settle_timer #(.CW(CW)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (ld),
      .load_val (ld_val),
      .expired  (expired)
   );

   // Each expiry performs the next pending step of whichever phase is
   // still outstanding, so phase changes cost no extra cycles.
   always_comb begin
      state_d = state_q;
      cur_v_d = cur_v_q;
      cur_f_d = cur_f_q;
      tv_d    = tv_q;
      tf_d    = tf_q;
      done_d  = 1'b0;
      ld      = 1'b0;
      ld_val  = '0;
      v_nxt   = cur_v_q;
      f_nxt   = cur_f_q;
      unique case (state_q)
         ST_IDLE: begin
            if (tgt_valid) begin
               tv_d    = tgt_v;
               tf_d    = tgt_f;
               state_d = (tgt_v > cur_v_q) ? ST_V_UP : ST_F_ADJ;
            end
         end
         ST_V_UP, ST_F_ADJ, ST_V_DN, ST_WAIT_DONE: begin
            if (expired) begin
               if (cur_v_q < tv_q) begin
                  v_nxt   = cur_v_q + VW'(1);
                  cur_v_d = v_nxt;
                  ld      = 1'b1;
                  ld_val  = V_LD;
                  state_d = (v_nxt == tv_q && cur_f_q == tf_q) ?
                            ST_WAIT_DONE : ST_V_UP;
               end else if (cur_f_q != tf_q) begin
                  f_nxt   = (cur_f_q < tf_q) ? cur_f_q + FW'(1)
                                             : cur_f_q - FW'(1);
                  cur_f_d = f_nxt;
                  ld      = 1'b1;
                  ld_val  = F_LD;
                  state_d = (f_nxt == tf_q && cur_v_q == tv_q) ?
                            ST_WAIT_DONE : ST_F_ADJ;
               end else if (cur_v_q > tv_q) begin
                  v_nxt   = cur_v_q - VW'(1);
                  cur_v_d = v_nxt;
                  ld      = 1'b1;
                  ld_val  = V_LD;
                  state_d = (v_nxt == tv_q) ? ST_WAIT_DONE : ST_V_DN;
               end else begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cur_v_q <= V_RST;
         cur_f_q <= F_RST;
         tv_q    <= V_RST;
         tf_q    <= F_RST;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cur_v_q <= cur_v_d;
         cur_f_q <= cur_f_d;
         tv_q    <= tv_d;
         tf_q    <= tf_d;
         done_q  <= done_d;
      end
   end

   assign tgt_ready = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign cur_v     = cur_v_q;
   assign cur_f     = cur_f_q;
   assign done      = done_q;

endmodule
